// File: rtl/exe_wb_arbiter.sv
// ---------------------------------------------------------------------------
// exe_wb_arbiter
//
// Merges the ALU, multiply-unit and divider results onto the single integer
// writeback port. The ALU always wins. MUL/DIV results that lose arbitration
// wait in a small in-order FIFO. Issue is throttled through mul_div_ready_o
// so results still travelling through the multiplier and divider always
// find room in that FIFO.
//
// Parameters:
//   DEPTH      FIFO entries for MUL/DIV results (power of 2, >= 4)
//   IN_FLIGHT  MUL/DIV results that may still arrive after ready drops
//
// Ports:
//   clk_i            clock
//   rstn_i           synchronous active-low reset
//   kill_i           flush buffered/incoming MUL/DIV results, the ALU input
//                    and the pending output
//   alu_instr_i      ALU result (used only when .valid)
//   mul_instr_i      multiply unit output
//   div_instr_i      divider output
//   wb_instr_o       registered writeback instruction
//   mul_div_ready_o  issue may send a new MUL/DIV when 1
//   overflow_o       sticky: a FIFO push was dropped because it was full
// ---------------------------------------------------------------------------

package exe_wb_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] result;
    } exe_wb_instr_t;

endpackage

module exe_wb_arbiter
    import exe_wb_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int IN_FLIGHT = 3
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          kill_i,
    input  exe_wb_instr_t alu_instr_i,
    input  exe_wb_instr_t mul_instr_i,
    input  exe_wb_instr_t div_instr_i,
    output exe_wb_instr_t wb_instr_o,
    output logic          mul_div_ready_o,
    output logic          overflow_o
);

    localparam int PW = $clog2(DEPTH);
    // One extra count bit so a full FIFO (count == DEPTH) differs from empty.
    localparam int CW = PW + 1;

    exe_wb_instr_t mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          fifo_empty;
    logic          pop;
    logic          bypass;
    exe_wb_instr_t bypass_instr;
    logic [CW:0]   free_slots;
    logic          accept_mul;
    logic          accept_div;
    logic          drop;

    // A lone MUL/DIV result skips the FIFO only when nothing is queued ahead
    // of it and the ALU is not using the port. When both arrive together
    // they are both queued (MUL first) to keep ordering simple.
    // free_slots counts the slot released by a same-cycle pop, so a full
    // FIFO being drained can still accept one new entry.
    always_comb begin
        fifo_empty   = (count == '0);
        bypass       = fifo_empty && !alu_instr_i.valid &&
                       (mul_instr_i.valid ^ div_instr_i.valid);
        bypass_instr = mul_instr_i.valid ? mul_instr_i : div_instr_i;
        pop          = !alu_instr_i.valid && !fifo_empty;
        free_slots   = (CW+1)'(DEPTH) - {1'b0, count} + {{CW{1'b0}}, pop};
        accept_mul   = mul_instr_i.valid && !bypass && (free_slots != '0);
        accept_div   = div_instr_i.valid && !bypass &&
                       (free_slots > {{CW{1'b0}}, accept_mul});
        drop         = (mul_instr_i.valid && !bypass && !accept_mul) ||
                       (div_instr_i.valid && !bypass && !accept_div);
    end

    // Ready looks only at the registered count, so it is stable for the
    // whole cycle and leaves IN_FLIGHT slots for results already launched.
    assign mul_div_ready_o = ((CW+1)'(DEPTH) - {1'b0, count}) > (CW+1)'(IN_FLIGHT);

    // Control state and output register. Kill empties the FIFO and blanks
    // the output but keeps the sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wb_instr_o <= '0;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            overflow_o <= 1'b0;
        end else if (kill_i) begin
            wb_instr_o.valid <= 1'b0;
            count            <= '0;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
        end else begin
            if (alu_instr_i.valid) begin
                wb_instr_o <= alu_instr_i;
            end else if (pop) begin
                wb_instr_o <= mem[rd_ptr];
            end else if (bypass) begin
                wb_instr_o <= bypass_instr;
            end else begin
                wb_instr_o.valid <= 1'b0;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            wr_ptr <= wr_ptr + PW'(accept_mul) + PW'(accept_div);
            count  <= count + CW'(accept_mul) + CW'(accept_div) - CW'(pop);

            if (drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // Payload storage has no reset: entries are only ever read after being
    // written, as tracked by count. The DIV entry goes in behind the MUL
    // entry when both are accepted in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rstn_i && !kill_i) begin
            if (accept_mul) begin
                mem[wr_ptr] <= mul_instr_i;
            end
            if (accept_div) begin
                mem[wr_ptr + PW'(accept_mul)] <= div_instr_i;
            end
        end
    end

endmodule

// File: tb/tb_exe_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_exe_wb_arbiter
//
// Directed bench for exe_wb_arbiter (DEPTH=4, IN_FLIGHT=3). Stimulus pushes
// the hand-ordered expected writeback stream into a queue; a monitor on the
// falling edge pops and compares every valid wb_instr_o. Ready, overflow
// and idle-output checks are made directly one step after each rising edge.
// ---------------------------------------------------------------------------

module tb_exe_wb_arbiter;
    import exe_wb_pkg::*;

    logic          clk;
    logic          rstn;
    logic          kill;
    exe_wb_instr_t alu_instr;
    exe_wb_instr_t mul_instr;
    exe_wb_instr_t div_instr;
    exe_wb_instr_t wb_instr;
    logic          ready;
    logic          overflow;

    exe_wb_instr_t exp_q[$];
    exe_wb_instr_t exp_head;
    int            checks = 0;
    int            passes = 0;

    exe_wb_arbiter #(
        .DEPTH     (4),
        .IN_FLIGHT (3)
    ) dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .kill_i          (kill),
        .alu_instr_i     (alu_instr),
        .mul_instr_i     (mul_instr),
        .div_instr_i     (div_instr),
        .wb_instr_o      (wb_instr),
        .mul_div_ready_o (ready),
        .overflow_o      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exe_wb_instr_t mk(input logic [31:0] pc,
                                         input logic [31:0] result,
                                         input logic [4:0]  rd);
        exe_wb_instr_t t;
        t.valid  = 1'b1;
        t.pc     = pc;
        t.rd     = rd;
        t.result = result;
        return t;
    endfunction

    // Non-valid input with a junk payload that must never reach writeback.
    function automatic exe_wb_instr_t idle();
        exe_wb_instr_t t;
        t.valid  = 1'b0;
        t.pc     = 32'hDEAD_BEEF;
        t.rd     = 5'd31;
        t.result = 32'hBAD0_BAD0;
        return t;
    endfunction

    task automatic expectOut(input exe_wb_instr_t x);
        exp_q.push_back(x);
    endtask

    task automatic applyStimulus(input exe_wb_instr_t a,
                                 input exe_wb_instr_t m,
                                 input exe_wb_instr_t d,
                                 input logic          k);
        alu_instr = a;
        mul_instr = m;
        div_instr = d;
        kill      = k;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string       name,
                               input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every valid writeback must match the queue head.
    always @(negedge clk) begin
        if (wb_instr.valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL wb_unexpected: got pc=0x%0h result=0x%0h, expected no output",
                         wb_instr.pc, wb_instr.result);
            end else begin
                exp_head = exp_q.pop_front();
                if (wb_instr.pc === exp_head.pc && wb_instr.result === exp_head.result &&
                    wb_instr.rd === exp_head.rd) begin
                    passes++;
                end else begin
                    $display("[TB] FAIL wb_order: got pc=0x%0h rd=%0d result=0x%0h, expected pc=0x%0h rd=%0d result=0x%0h",
                             wb_instr.pc, wb_instr.rd, wb_instr.result,
                             exp_head.pc, exp_head.rd, exp_head.result);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstn      = 1'b0;
        kill      = 1'b0;
        alu_instr = '0;
        mul_instr = '0;
        div_instr = '0;

        // Reset state
        applyStimulus(idle(), idle(), idle(), 1'b0);
        applyStimulus(idle(), idle(), idle(), 1'b0);
        checkOutput("reset_wb_pc",     wb_instr.pc,     32'h0);
        checkOutput("reset_wb_valid",  32'(wb_instr.valid), 32'h0);
        checkOutput("reset_ready",     32'(ready),      32'h1);
        checkOutput("reset_overflow",  32'(overflow),   32'h0);
        rstn = 1'b1;
        applyStimulus(idle(), idle(), idle(), 1'b0);

        // Single MUL bypasses the empty FIFO with 1-cycle latency
        expectOut(mk(32'h80, 32'h2A, 5'd1));
        applyStimulus(idle(), mk(32'h80, 32'h2A, 5'd1), idle(), 1'b0);
        checkOutput("bypass_mul_ready", 32'(ready), 32'h1);
        applyStimulus(idle(), idle(), idle(), 1'b0);
        checkOutput("bypass_then_idle", 32'(wb_instr.valid), 32'h0);

        // Lone DIV also bypasses
        expectOut(mk(32'h84, 32'h7, 5'd2));
        applyStimulus(idle(), idle(), mk(32'h84, 32'h7, 5'd2), 1'b0);
        checkOutput("bypass_div_ready", 32'(ready), 32'h1);
        applyStimulus(idle(), idle(), idle(), 1'b0);

        // ALU for 3 cycles, MUL A and B queue behind it
        expectOut(mk(32'h100, 32'h1, 5'd3));
        expectOut(mk(32'h104, 32'h2, 5'd3));
        expectOut(mk(32'h108, 32'h3, 5'd3));
        expectOut(mk(32'h200, 32'hA, 5'd4));
        expectOut(mk(32'h204, 32'hB, 5'd5));
        applyStimulus(mk(32'h100, 32'h1, 5'd3), idle(), idle(), 1'b0);
        applyStimulus(mk(32'h104, 32'h2, 5'd3), mk(32'h200, 32'hA, 5'd4), idle(), 1'b0);
        checkOutput("alu_pri_ready_cnt1", 32'(ready), 32'h0);
        applyStimulus(mk(32'h108, 32'h3, 5'd3), mk(32'h204, 32'hB, 5'd5), idle(), 1'b0);
        applyStimulus(idle(), idle(), idle(), 1'b0);
        applyStimulus(idle(), idle(), idle(), 1'b0);
        checkOutput("alu_pri_drained_ready", 32'(ready), 32'h1);
        applyStimulus(idle(), idle(), idle(), 1'b0);

        // MUL + DIV together while ALU valid: ALU, then MUL, then DIV
        expectOut(mk(32'h300, 32'h30, 5'd6));
        expectOut(mk(32'h310, 32'h31, 5'd7));
        expectOut(mk(32'h320, 32'h32, 5'd8));
        applyStimulus(mk(32'h300, 32'h30, 5'd6), mk(32'h310, 32'h31, 5'd7),
                      mk(32'h320, 32'h32, 5'd8), 1'b0);
        checkOutput("dual_push_ready", 32'(ready), 32'h0);
        applyStimulus(idle(), idle(), idle(), 1'b0);
        applyStimulus(idle(), idle(), idle(), 1'b0);
        checkOutput("dual_push_drained", 32'(ready), 32'h1);
        applyStimulus(idle(), idle(), idle(), 1'b0);

        // MUL + DIV together with no ALU: no bypass, both queued in order
        expectOut(mk(32'h400, 32'h40, 5'd9));
        expectOut(mk(32'h410, 32'h41, 5'd10));
        applyStimulus(idle(), mk(32'h400, 32'h40, 5'd9), mk(32'h410, 32'h41, 5'd10), 1'b0);
        checkOutput("dual_nobypass_valid", 32'(wb_instr.valid), 32'h0);
        checkOutput("dual_nobypass_ready", 32'(ready), 32'h0);
        applyStimulus(idle(), idle(), idle(), 1'b0);
        applyStimulus(idle(), idle(), idle(), 1'b0);
        applyStimulus(idle(), idle(), idle(), 1'b0);

        // ALU held, issue honours ready: ready falls at count 1
        expectOut(mk(32'h500, 32'h50, 5'd11));
        expectOut(mk(32'h504, 32'h51, 5'd11));
        expectOut(mk(32'h510, 32'h52, 5'd12));
        checkOutput("ready_at_cnt0", 32'(ready), 32'h1);
        applyStimulus(mk(32'h500, 32'h50, 5'd11), mk(32'h510, 32'h52, 5'd12), idle(), 1'b0);
        checkOutput("ready_at_cnt1", 32'(ready), 32'h0);
        applyStimulus(mk(32'h504, 32'h51, 5'd11), idle(), idle(), 1'b0);
        checkOutput("ready_honoured_ovf", 32'(overflow), 32'h0);
        applyStimulus(idle(), idle(), idle(), 1'b0);
        applyStimulus(idle(), idle(), idle(), 1'b0);

        // Fill to count 3, then kill with a valid MUL and ALU
        expectOut(mk(32'h600, 32'h60, 5'd13));
        expectOut(mk(32'h604, 32'h61, 5'd13));
        applyStimulus(mk(32'h600, 32'h60, 5'd13), mk(32'h610, 32'h62, 5'd14),
                      mk(32'h620, 32'h63, 5'd15), 1'b0);
        applyStimulus(mk(32'h604, 32'h61, 5'd13), mk(32'h614, 32'h64, 5'd14), idle(), 1'b0);
        checkOutput("kill_pre_ready", 32'(ready), 32'h0);
        applyStimulus(mk(32'h608, 32'h65, 5'd13), mk(32'h618, 32'h66, 5'd14), idle(), 1'b1);
        checkOutput("kill_wb_valid", 32'(wb_instr.valid), 32'h0);
        checkOutput("kill_ready",    32'(ready), 32'h1);
        applyStimulus(idle(), idle(), idle(), 1'b0);
        checkOutput("kill_after_valid", 32'(wb_instr.valid), 32'h0);
        applyStimulus(idle(), idle(), idle(), 1'b0);
        checkOutput("kill_no_overflow", 32'(overflow), 32'h0);

        // Ignore ready: 2 pushes per cycle under ALU, the 5th entry drops
        expectOut(mk(32'h700, 32'h70, 5'd16));
        expectOut(mk(32'h704, 32'h71, 5'd16));
        expectOut(mk(32'h708, 32'h72, 5'd16));
        expectOut(mk(32'h710, 32'h73, 5'd17));
        expectOut(mk(32'h720, 32'h74, 5'd18));
        expectOut(mk(32'h714, 32'h75, 5'd17));
        expectOut(mk(32'h724, 32'h76, 5'd18));
        applyStimulus(mk(32'h700, 32'h70, 5'd16), mk(32'h710, 32'h73, 5'd17),
                      mk(32'h720, 32'h74, 5'd18), 1'b0);
        applyStimulus(mk(32'h704, 32'h71, 5'd16), mk(32'h714, 32'h75, 5'd17),
                      mk(32'h724, 32'h76, 5'd18), 1'b0);
        checkOutput("full_no_overflow", 32'(overflow), 32'h0);
        applyStimulus(mk(32'h708, 32'h72, 5'd16), mk(32'h718, 32'h77, 5'd17),
                      mk(32'h728, 32'h78, 5'd18), 1'b0);
        checkOutput("overflow_set", 32'(overflow), 32'h1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(idle(), idle(), idle(), 1'b0);
        end
        checkOutput("overflow_sticky", 32'(overflow), 32'h1);
        rstn = 1'b0;
        applyStimulus(idle(), idle(), idle(), 1'b0);
        checkOutput("overflow_cleared", 32'(overflow), 32'h0);
        rstn = 1'b1;
        applyStimulus(idle(), idle(), idle(), 1'b0);

        // Reset mid-operation drops queued entries
        expectOut(mk(32'h800, 32'h80, 5'd19));
        applyStimulus(mk(32'h800, 32'h80, 5'd19), mk(32'h810, 32'h81, 5'd20),
                      mk(32'h820, 32'h82, 5'd21), 1'b0);
        rstn = 1'b0;
        applyStimulus(idle(), idle(), idle(), 1'b0);
        checkOutput("midreset_wb_valid", 32'(wb_instr.valid), 32'h0);
        checkOutput("midreset_ready",    32'(ready), 32'h1);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(idle(), idle(), idle(), 1'b0);
        end

        checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
